readout_rx_meas_scheduler: RTL and testbench

Time-multiplexes one shared readout-RX integration/state-decision datapath across `NUM_QUBITS` qubit channels. Per-qubit measurement requests are queued as pending bits and granted round-robin. For each grant the block routes the qubit channel, clears and enables the integrator for a programmable window, then fires a one-cycle `finish_count` pulse into the state-decision output logic. It captures the returned decision and emits it tagged with the qubit index. The block sits between the readout sequencer (request side) and the integrator/decision datapath.

---
 rtl/readout_rx_pkg.sv | 6 +
 rtl/readout_rx_rr_arbiter.sv | 28 ++
 rtl/readout_rx_meas_scheduler.sv | 126 ++++++++++++
 tb/tb_readout_rx_meas_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_rx_pkg.sv
// readout_rx_pkg: FSM state encoding and default widths shared by the readout RX scheduler
package readout_rx_pkg;
  localparam int INTEG_W_DEF  = 10;
  localparam int WAIT_MAX_DEF = 4;
  typedef enum logic [2:0] {S_IDLE, S_START, S_INTEG, S_FINISH, S_WAIT} state_t;
endpackage

// File: rtl/readout_rx_rr_arbiter.sv
// readout_rx_rr_arbiter: combinational round-robin pick over the pending vector
//   pending_in    : per-qubit pending bits
//   last_grant_in : previously granted qubit; search starts one above it
//   any_out       : at least one qubit pending
//   winner_out    : first pending qubit at or after last_grant_in+1 (wrapping)
module readout_rx_rr_arbiter
  import readout_rx_pkg::*;
#(
  parameter int NUM_QUBITS = 8,
  parameter int QID_W      = $clog2(NUM_QUBITS)
) (
  input  logic [NUM_QUBITS-1:0] pending_in,
  input  logic [QID_W-1:0]      last_grant_in,
  output logic                  any_out,
  output logic [QID_W-1:0]      winner_out
);
  logic [QID_W-1:0] idx;
  // Walk from the farthest candidate back to the nearest so the nearest pending qubit wins.
  always_comb begin
    any_out    = |pending_in;
    winner_out = '0;
    idx        = '0;
    for (int k = NUM_QUBITS; k >= 1; k--) begin
      idx = QID_W'((int'(last_grant_in) + k) % NUM_QUBITS);
      if (pending_in[idx]) winner_out = idx;
    end
  end
endmodule

// File: rtl/readout_rx_meas_scheduler.sv
// readout_rx_meas_scheduler: round-robin scheduler sharing one integrate/decide datapath across qubits
//   clk, rst (sync, active-low)
//   req_in / integ_len_in                 : measurement requests and integration length
//   busy_out, sel_qubit_out               : scheduler activity and routed channel
//   start_integ_out / accum_en_out        : integrator clear and enable
//   finish_count_out                      : pulse into the decision logic
//   valid_meas_result_in / meas_result_in : decision returned by the decision logic
//   result_valid_out/result_qubit_out/result_out : tagged decision strobe
//   dropped_out / timeout_out             : duplicate-request and missing-decision pulses
module readout_rx_meas_scheduler
  import readout_rx_pkg::*;
#(
  parameter int NUM_QUBITS = 8,
  parameter int QID_W      = $clog2(NUM_QUBITS),
  parameter int INTEG_W    = INTEG_W_DEF,
  parameter int WAIT_MAX   = WAIT_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_QUBITS-1:0] req_in,
  input  logic [INTEG_W-1:0]    integ_len_in,
  output logic                  busy_out,
  output logic [QID_W-1:0]      sel_qubit_out,
  output logic                  start_integ_out,
  output logic                  accum_en_out,
  output logic                  finish_count_out,
  input  logic                  valid_meas_result_in,
  input  logic                  meas_result_in,
  output logic                  result_valid_out,
  output logic [QID_W-1:0]      result_qubit_out,
  output logic                  result_out,
  output logic                  dropped_out,
  output logic                  timeout_out
);
  localparam int WC_W = $clog2(WAIT_MAX + 1);
  state_t state_q, state_d;
  logic [NUM_QUBITS-1:0] pending_q, pending_d, grant_mask;
  logic [INTEG_W-1:0] cnt_q, cnt_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [QID_W-1:0] sel_q, sel_d, last_q, last_d, res_qubit_q, res_qubit_d, winner;
  logic res_valid_q, res_valid_d, res_q, res_d, drop_q, drop_d, tmo_q, tmo_d;
  logic any_req, grant, wait_done;
  readout_rx_rr_arbiter #(.NUM_QUBITS(NUM_QUBITS), .QID_W(QID_W)) u_arb (
    .pending_in   (pending_q),
    .last_grant_in(last_q),
    .any_out      (any_req),
    .winner_out   (winner)
  );
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    grant       = 1'b0;
    wait_done   = state_q == S_WAIT && (valid_meas_result_in || wcnt_q == '0);
    res_valid_d = state_q == S_WAIT && valid_meas_result_in;
    res_qubit_d = res_valid_d ? sel_q : res_qubit_q;
    res_d       = res_valid_d ? meas_result_in : res_q;
    tmo_d       = wait_done && !valid_meas_result_in;
    case (state_q)
      S_START:  state_d = S_INTEG;
      S_INTEG: begin
        state_d = cnt_q == '0 ? S_FINISH : S_INTEG;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - INTEG_W'(1);
      end
      S_FINISH: begin
        state_d = S_WAIT;
        wcnt_d  = WC_W'(WAIT_MAX - 1);
      end
      S_WAIT:   wcnt_d = wait_done ? wcnt_q : wcnt_q - WC_W'(1);
      default:  state_d = state_q;
    endcase
    // A finished WAIT chains straight into the next grant, skipping IDLE.
    if ((state_q == S_IDLE || wait_done) && any_req) begin
      grant   = 1'b1;
      state_d = S_START;
      sel_d   = winner;
      last_d  = winner;
      cnt_d   = integ_len_in == '0 ? '0 : integ_len_in - INTEG_W'(1);
    end else if (wait_done) begin
      state_d = S_IDLE;
    end
    grant_mask = grant ? NUM_QUBITS'(1) << winner : '0;
    // A request landing on the grant cycle re-queues the qubit rather than being dropped.
    pending_d  = (pending_q & ~grant_mask) | req_in;
    drop_d     = |(req_in & pending_q & ~grant_mask);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      sel_q       <= '0;
      last_q      <= QID_W'(NUM_QUBITS - 1);
      res_valid_q <= 1'b0;
      res_qubit_q <= '0;
      res_q       <= 1'b0;
      drop_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
      res_qubit_q <= res_qubit_d;
      res_q       <= res_d;
      drop_q      <= drop_d;
      tmo_q       <= tmo_d;
    end
  end
  assign busy_out         = state_q != S_IDLE;
  assign start_integ_out  = state_q == S_START;
  assign accum_en_out     = state_q == S_INTEG;
  assign finish_count_out = state_q == S_FINISH;
  assign sel_qubit_out    = sel_q;
  assign result_valid_out = res_valid_q;
  assign result_qubit_out = res_qubit_q;
  assign result_out       = res_q;
  assign dropped_out      = drop_q;
  assign timeout_out      = tmo_q;
endmodule

// File: tb/tb_readout_rx_meas_scheduler.sv
// tb_readout_rx_meas_scheduler: directed vectors and sequences for the readout RX scheduler
module tb_readout_rx_meas_scheduler;
  localparam int N  = 8;
  localparam int QW = 3;
  localparam int IW = 10;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req_in = '0;
  logic [IW-1:0] integ_len_in = '0;
  logic valid_meas_result_in = 1'b0;
  logic meas_result_in = 1'b0;
  logic busy_out, start_integ_out, accum_en_out, finish_count_out;
  logic result_valid_out, result_out, dropped_out, timeout_out;
  logic [QW-1:0] sel_qubit_out, result_qubit_out;
  readout_rx_meas_scheduler #(.NUM_QUBITS(N), .INTEG_W(IW), .WAIT_MAX(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_in              (req_in),
    .integ_len_in        (integ_len_in),
    .busy_out            (busy_out),
    .sel_qubit_out       (sel_qubit_out),
    .start_integ_out     (start_integ_out),
    .accum_en_out        (accum_en_out),
    .finish_count_out    (finish_count_out),
    .valid_meas_result_in(valid_meas_result_in),
    .meas_result_in      (meas_result_in),
    .result_valid_out    (result_valid_out),
    .result_qubit_out    (result_qubit_out),
    .result_out          (result_out),
    .dropped_out         (dropped_out),
    .timeout_out         (timeout_out)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int dec_lat = 1;
  logic dec_bit = 1'b1;
  logic dec_alt = 1'b0;
  int k = 0;
  // Decision-logic model: answers dec_lat cycles after finish_count_out (0 = never answers).
  initial forever begin
    @(posedge clk);
    #1;
    valid_meas_result_in = 1'b0;
    if (k > 0) begin
      if (k == 1) begin
        valid_meas_result_in = 1'b1;
        meas_result_in = dec_bit;
        if (dec_alt) dec_bit = ~dec_bit;
      end
      k--;
    end
    if (finish_count_out) k = dec_lat;
  end
  int nres = 0, ndrop = 0, nfin = 0;
  int rq_log[64];
  int rc_log[64];
  logic rb_log[64];
  initial forever begin
    @(posedge clk);
    #1;
    if (result_valid_out && nres < 64) begin
      rq_log[nres] = int'(result_qubit_out);
      rb_log[nres] = result_out;
      rc_log[nres] = cyc;
      nres++;
    end
    if (dropped_out) ndrop++;
    if (finish_count_out) nfin++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got time limit required $finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    req_in = '0;
    repeat (2) tick();
    rst = 1'b1;
  endtask
  task automatic wait_res(input int target, input int budget, input string nm);
    int c = 0;
    while (nres < target && c < budget) begin
      tick();
      c++;
    end
    chk(nm, nres, target);
  endtask
  // {busy, start, accum, finish, dropped, timeout, result_valid, sel[2:0]}
  function automatic logic [9:0] ov();
    return {busy_out, start_integ_out, accum_en_out, finish_count_out, dropped_out,
            timeout_out, result_valid_out, sel_qubit_out};
  endfunction
  typedef struct {
    logic [N-1:0]  req;
    logic [IW-1:0] len;
    logic [9:0]    exp;
    logic [3:0]    rqb;
  } vec_t;
  vec_t vec[12];
  initial begin
    int base, d0, f0, gap, c, busy_cnt;
    logic started;
    for (int i = 0; i < 12; i++) vec[i] = '{8'h00, 10'd5, 10'b0, 4'h0};
    vec[0].req = 8'h01;
    vec[2].exp = 10'b1100000_000;
    for (int i = 3; i <= 7; i++) vec[i].exp = 10'b1010000_000;
    vec[8].exp  = 10'b1001000_000;
    vec[9].exp  = 10'b1000000_000;
    vec[10].exp = 10'b0000001_000;
    vec[10].rqb = 4'b0001;
    // single request, L=5, decision 1 in the first WAIT cycle
    dec_lat = 1; dec_bit = 1'b1; dec_alt = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req_in = vec[i].req;
      integ_len_in = vec[i].len;
      chk($sformatf("vec%0d", i), ov(), vec[i].exp);
      if (vec[i].exp[3]) chk($sformatf("vec%0d_res", i), {result_qubit_out, result_out}, vec[i].rqb);
    end_tick: tick();
    end
    // all eight qubits at once, L=2, decisions alternate starting with 1
    do_reset();
    dec_lat = 2; dec_bit = 1'b1; dec_alt = 1'b1;
    integ_len_in = 10'd2;
    base = nres;
    req_in = 8'hFF;
    tick();
    req_in = '0;
    gap = 0; started = 1'b0; c = 0;
    while (nres < base + 8 && c < 200) begin
      if (busy_out) started = 1'b1;
      if (started && !busy_out) gap++;
      tick();
      c++;
    end
    chk("rr8_count", nres, base + 8);
    chk("rr8_busy_gap", gap, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rr8_res%0d", i), rq_log[base + i] * 2 + int'(rb_log[base + i]), i * 2 + ((i % 2 == 0) ? 1 : 0));
    for (int i = 1; i < 8; i++) chk($sformatf("rr8_space%0d", i), rc_log[base + i] - rc_log[base + i - 1], 6);
    dec_alt = 1'b0;
    // grant 3 first, then {2,5} pending: order 5 then 2
    do_reset();
    dec_lat = 1; dec_bit = 1'b1;
    integ_len_in = 10'd1;
    base = nres;
    req_in = 8'h08;
    tick();
    req_in = '0;
    tick();
    req_in = 8'h24;
    tick();
    req_in = '0;
    wait_res(base + 3, 100, "rr_wait");
    chk("rr_first", rq_log[base], 3);
    chk("rr_second", rq_log[base + 1], 5);
    chk("rr_third", rq_log[base + 2], 2);
    // duplicate request on an already-pending qubit 4
    do_reset();
    base = nres; d0 = ndrop;
    req_in = 8'h11;
    tick();
    req_in = '0;
    tick();
    req_in = 8'h10;
    chk("drop_before", dropped_out, 0);
    tick();
    req_in = '0;
    chk("drop_pulse", dropped_out, 1);
    tick();
    chk("drop_single", dropped_out, 0);
    wait_res(base + 2, 100, "drop_wait");
    repeat (20) tick();
    chk("drop_results", nres, base + 2);
    chk("drop_q4", rq_log[base + 1], 4);
    chk("drop_count", ndrop - d0, 1);
    // request for qubit 4 in its own grant cycle re-queues it
    do_reset();
    base = nres; d0 = ndrop;
    req_in = 8'h11;
    tick();
    req_in = '0;
    repeat (4) tick();
    chk("requeue_wait_state", {busy_out, start_integ_out, accum_en_out, finish_count_out}, 4'b1000);
    req_in = 8'h10;
    tick();
    req_in = '0;
    wait_res(base + 3, 100, "requeue_wait");
    repeat (20) tick();
    chk("requeue_results", nres, base + 3);
    chk("requeue_order", rq_log[base] * 100 + rq_log[base + 1] * 10 + rq_log[base + 2], 44);
    chk("requeue_nodrop", ndrop - d0, 0);
    // decision never returns: timeout after WAIT_MAX WAIT cycles
    do_reset();
    dec_lat = 0;
    base = nres;
    req_in = 8'h02;
    tick();
    req_in = '0;
    repeat (3) tick();
    chk("tmo_finish", finish_count_out, 1);
    repeat (4) tick();
    chk("tmo_wait_last", {timeout_out, busy_out, result_valid_out}, 3'b010);
    tick();
    chk("tmo_pulse", {timeout_out, busy_out, result_valid_out}, 3'b100);
    tick();
    chk("tmo_single", timeout_out, 0);
    repeat (10) tick();
    chk("tmo_no_result", nres, base);
    chk("tmo_idle", busy_out, 0);
    // integ_len_in=0 behaves as one INTEG cycle
    do_reset();
    dec_lat = 1;
    integ_len_in = 10'd0;
    base = nres;
    req_in = 8'h04;
    tick();
    req_in = '0;
    tick();
    chk("len0_start", start_integ_out, 1);
    tick();
    chk("len0_integ", {accum_en_out, finish_count_out}, 2'b10);
    tick();
    chk("len0_finish", {accum_en_out, finish_count_out}, 2'b01);
    wait_res(base + 1, 20, "len0_wait");
    chk("len0_qubit", rq_log[base], 2);
    // reset asserted during INTEG aborts the measurement
    do_reset();
    integ_len_in = 10'd5;
    base = nres; f0 = nfin;
    req_in = 8'h04;
    tick();
    req_in = '0;
    repeat (3) tick();
    chk("abort_integ", {accum_en_out, sel_qubit_out}, 4'b1010);
    rst = 1'b0;
    tick();
    chk("abort_outs", {ov(), result_qubit_out, result_out}, 14'h0);
    rst = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy_out) busy_cnt++;
      tick();
    end
    chk("abort_pending_clear", busy_cnt, 0);
    chk("abort_no_finish", nfin - f0, 0);
    chk("abort_no_result", nres, base);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
